// File: rtl/m_axi_lite_write_pkg.sv
// rtl/m_axi_lite_write_pkg.sv - shared types and constants for the AXI4-Lite write master and responder
package m_axi_lite_write_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int STRB_W    = 4;
    localparam int MEM_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge new_word into old_word, byte lane by byte lane, where strb is set.
    function automatic logic [DATA_W-1:0] apply_strb(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/s_axi_lite.sv
// rtl/s_axi_lite.sv - AXI4-Lite write responder backed by a 32-word strobe-masked memory
import m_axi_lite_write_pkg::*;

module s_axi_lite (
    input  logic              clk,
    input  logic              resetn,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              aw_got;
    logic              w_got;
    logic [4:0]        addr_q;
    logic [DATA_W-1:0] data_q;
    logic [STRB_W-1:0] strb_q;
    logic              awaddr_unused;

    // Only the low five address bits select a word.
    assign awaddr_unused = ^awaddr[ADDR_W-1:5];
    assign rd_data       = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Ready is a one-cycle pulse, raised the cycle after valid is seen.
            awready <= awvalid && !awready && !aw_got;
            wready  <= wvalid && !wready && !w_got;

            if (awvalid && awready) begin
                aw_got <= 1'b1;
                addr_q <= awaddr[4:0];
            end
            if (wvalid && wready) begin
                w_got  <= 1'b1;
                data_q <= wdata;
                strb_q <= wstrb;
            end

            if (aw_got && w_got && !bvalid) begin
                mem[addr_q] <= apply_strb(mem[addr_q], data_q, strb_q);
                bvalid      <= 1'b1;
                bresp       <= RESP_OKAY;
            end

            if (bvalid && bready) begin
                bvalid <= 1'b0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/m_axi_lite_write.sv
// rtl/m_axi_lite_write.sv - AXI4-Lite write-only master: latch request, drive AW/W, wait for B
import m_axi_lite_write_pkg::*;

module m_axi_lite_write (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_din,
    input  logic [STRB_W-1:0] i_strb,
    input  logic [ADDR_W-1:0] i_addrin,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp
);

    state_t state;
    logic   aw_fire;
    logic   w_fire;
    logic   aw_done;
    logic   w_done;
    logic   bresp_unused;

    assign aw_fire = m_axi_awvalid && m_axi_awready;
    assign w_fire  = m_axi_wvalid && m_axi_wready;

    // A channel counts as done if it already completed or completes on this edge.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid || m_axi_wready;

    // Every response code is accepted; there is no retry path.
    assign bresp_unused = ^m_axi_bresp;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state         <= IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_wr) begin
                        m_axi_awaddr  <= i_addrin;
                        m_axi_wdata   <= i_din;
                        m_axi_wstrb   <= i_strb;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_axi_lite_write.sv
// tb/tb_m_axi_lite_write.sv - self-checking bench for m_axi_lite_write with s_axi_lite or a scripted slave
module tb_m_axi_lite_write;

    logic        clk;
    logic        resetn;
    logic        i_wr;
    logic [31:0] i_din;
    logic [3:0]  i_strb;
    logic [31:0] i_addrin;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;

    logic        awready_s;
    logic        wready_s;
    logic        bvalid_s;
    logic [1:0]  bresp_s;

    logic        sl_awready;
    logic        sl_wready;
    logic        sl_bvalid;
    logic [1:0]  sl_bresp;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    logic        use_drv;
    int          aw_delay;
    int          w_delay;
    int          aw_cnt;
    int          w_cnt;
    logic [1:0]  drv_resp;
    logic        force_bvalid;

    int          checks;
    int          errors;

    logic        m_busy;
    logic        m_aw;
    logic        m_w;
    logic        m_b;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    int          n_sampled;
    logic [31:0] exp_mem [32];

    logic [31:0] aw_q [$];
    logic [31:0] w_q [$];
    int          n_b;
    logic [1:0]  last_bresp;
    int          aw_hi;
    int          w_hi;
    logic        bready_early;

    m_axi_lite_write dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_wr          (i_wr),
        .i_din         (i_din),
        .i_strb        (i_strb),
        .i_addrin      (i_addrin),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready_s),
        .m_axi_awaddr  (awaddr),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready_s),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_bvalid  (bvalid_s),
        .m_axi_bready  (bready),
        .m_axi_bresp   (bresp_s)
    );

    s_axi_lite slave (
        .clk     (clk),
        .resetn  (resetn),
        .awvalid (awvalid && !use_drv),
        .awready (sl_awready),
        .awaddr  (awaddr),
        .wvalid  (wvalid && !use_drv),
        .wready  (sl_wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (sl_bvalid),
        .bready  (bready && !use_drv),
        .bresp   (sl_bresp),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign awready_s = use_drv ? (awvalid && (aw_cnt > aw_delay)) : sl_awready;
    assign wready_s  = use_drv ? (wvalid && (w_cnt > w_delay)) : sl_wready;
    assign bvalid_s  = use_drv ? (bready || force_bvalid) : sl_bvalid;
    assign bresp_s   = use_drv ? drv_resp : sl_bresp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scripted slave: count how long each valid has been waiting.
    always @(posedge clk) begin
        #1;
        aw_cnt = awvalid ? aw_cnt + 1 : 0;
        w_cnt  = wvalid ? w_cnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: compare outputs, log handshakes, then advance on this cycle's inputs.
    always @(negedge clk) begin
        chk("awvalid", {31'b0, awvalid}, {31'b0, m_aw});
        chk("wvalid", {31'b0, wvalid}, {31'b0, m_w});
        chk("bready", {31'b0, bready}, {31'b0, m_b});
        chk("awaddr", awaddr, m_addr);
        chk("wdata", wdata, m_data);
        chk("wstrb", {28'b0, wstrb}, {28'b0, m_strb});

        if (resetn) begin
            if (awvalid && awready_s) aw_q.push_back(awaddr);
            if (wvalid && wready_s) w_q.push_back(wdata);
            if (bready && bvalid_s) begin
                n_b++;
                last_bresp = bresp_s;
            end
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (bready && awvalid) bready_early = 1'b1;
        end

        if (!resetn) begin
            m_busy = 0; m_aw = 0; m_w = 0; m_b = 0;
            m_addr = 0; m_data = 0; m_strb = 0;
            for (int i = 0; i < 32; i++) exp_mem[i] = 0;
        end else if (!m_busy) begin
            if (i_wr) begin
                logic [31:0] mask;
                m_busy = 1; m_aw = 1; m_w = 1;
                m_addr = i_addrin; m_data = i_din; m_strb = i_strb;
                n_sampled++;
                if (!use_drv) begin
                    mask = {{8{i_strb[3]}}, {8{i_strb[2]}}, {8{i_strb[1]}}, {8{i_strb[0]}}};
                    exp_mem[i_addrin % 32] = (exp_mem[i_addrin % 32] & ~mask) | (i_din & mask);
                end
            end
        end else if (m_aw || m_w) begin
            if (m_aw && awready_s) m_aw = 0;
            if (m_w && wready_s) m_w = 0;
            if (!m_aw && !m_w) m_b = 1;
        end else if (m_b && bvalid_s) begin
            m_b = 0;
            m_busy = 0;
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input bit keep_wr);
        int start;
        start    = n_sampled;
        i_addrin = addr;
        i_din    = data;
        i_strb   = strb;
        i_wr     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (n_sampled != start) begin
                if (!keep_wr) i_wr = 1'b0;
                return;
            end
        end
        i_wr = 1'b0;
        chk("sample_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (!m_busy) return;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_mem(input string name, input logic [4:0] idx, input logic [31:0] exp);
        rd_addr = idx;
        #1;
        chk(name, rd_data, exp);
    endtask

    logic [31:0] seq_addr [10] = '{4, 17, 0, 20, 9, 4, 12, 1, 15, 7};
    logic [31:0] seq_data [10] = '{3, 8, 1, 10, 5, 6, 2, 9, 4, 7};

    initial begin
        int base_aw;
        int base_w;
        int base_b;
        int base_s;

        checks = 0; errors = 0;
        resetn = 0; i_wr = 0; i_din = 0; i_strb = 0; i_addrin = 0;
        use_drv = 0; aw_delay = 0; w_delay = 0; aw_cnt = 0; w_cnt = 0;
        drv_resp = 2'b00; force_bvalid = 0; rd_addr = 0;
        m_busy = 0; m_aw = 0; m_w = 0; m_b = 0; m_addr = 0; m_data = 0; m_strb = 0;
        n_sampled = 0; n_b = 0; last_bresp = 2'b11; aw_hi = 0; w_hi = 0; bready_early = 0;
        for (int i = 0; i < 32; i++) exp_mem[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_awvalid", {31'b0, awvalid}, 32'd0);
        chk("reset_bready", {31'b0, bready}, 32'd0);
        chk("reset_awaddr", awaddr, 32'd0);
        @(posedge clk); #1;
        resetn = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_start_without_wr", n_sampled, 32'd0);

        // Single write through the responder.
        base_aw = aw_q.size(); base_w = w_q.size(); base_b = n_b;
        issue(32'd5, 32'd7, 4'hF, 1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("single_b_count", n_b - base_b, 32'd1);
        chk("single_awaddr", aw_q[base_aw], 32'd5);
        chk("single_wdata", w_q[base_w], 32'd7);
        chk("single_bresp", {30'b0, last_bresp}, 32'd0);
        chk_mem("single_mem5", 5'd5, 32'd7);

        // AW delayed three cycles, W immediate.
        @(posedge clk); #1;
        use_drv = 1; aw_delay = 3; w_delay = 0; drv_resp = 2'b00;
        aw_hi = 0; w_hi = 0; bready_early = 0;
        base_aw = aw_q.size(); base_b = n_b;
        issue(32'h100, 32'hDEADBEEF, 4'hA, 1'b0);
        wait_idle();
        #1;
        chk("slow_aw_hi", aw_hi, 32'd4);
        chk("slow_w_hi", w_hi, 32'd1);
        chk("slow_bready_early", {31'b0, bready_early}, 32'd0);
        chk("slow_b_count", n_b - base_b, 32'd1);
        chk("slow_awaddr", aw_q[base_aw], 32'h100);

        // Ten back-to-back writes with i_wr held high.
        @(posedge clk); #1;
        use_drv = 0;
        base_aw = aw_q.size(); base_w = w_q.size(); base_b = n_b;
        for (int k = 0; k < 10; k++) begin
            issue(seq_addr[k], seq_data[k], 4'hF, (k != 9));
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_aw_count", aw_q.size() - base_aw, 32'd10);
        chk("b2b_w_count", w_q.size() - base_w, 32'd10);
        chk("b2b_b_count", n_b - base_b, 32'd10);
        for (int k = 0; k < 10; k++) begin
            chk("b2b_awaddr", aw_q[base_aw + k], seq_addr[k]);
            chk("b2b_wdata", w_q[base_w + k], seq_data[k]);
        end
        for (int a = 0; a < 32; a++) begin
            chk_mem("b2b_mem", a[4:0], exp_mem[a]);
        end
        chk_mem("b2b_mem4", 5'd4, 32'd6);
        chk_mem("b2b_mem20", 5'd20, 32'd10);

        // Address changed while the first write is in flight.
        base_aw = aw_q.size();
        issue(32'd3, 32'h11, 4'hF, 1'b1);
        issue(32'd9, 32'hAABBCCDD, 4'b0101, 1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("chg_first_addr", aw_q[base_aw], 32'd3);
        chk("chg_second_addr", aw_q[base_aw + 1], 32'd9);
        chk_mem("chg_mem3", 5'd3, 32'h11);
        chk_mem("chg_mem9", 5'd9, 32'h00BB00DD);

        // Reset in the middle of SEND.
        @(posedge clk); #1;
        use_drv = 1; aw_delay = 20; w_delay = 20;
        base_aw = aw_q.size(); base_w = w_q.size(); base_b = n_b;
        issue(32'h44, 32'h55, 4'hF, 1'b0);
        @(posedge clk); #1;
        resetn = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_awvalid", {31'b0, awvalid}, 32'd0);
        chk("midrst_wvalid", {31'b0, wvalid}, 32'd0);
        chk("midrst_bready", {31'b0, bready}, 32'd0);
        chk("midrst_wdata", wdata, 32'd0);
        @(posedge clk); #1;
        resetn = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_b_count", n_b - base_b, 32'd0);
        chk("midrst_aw_count", aw_q.size() - base_aw, 32'd0);
        chk("midrst_w_count", w_q.size() - base_w, 32'd0);
        chk_mem("midrst_mem9", 5'd9, 32'd0);

        // SLVERR response completes without retry; stray bvalid in IDLE is ignored.
        aw_delay = 0; w_delay = 0; drv_resp = 2'b10;
        base_aw = aw_q.size(); base_b = n_b;
        issue(32'h30, 32'h1234, 4'hF, 1'b0);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("slverr_aw_count", aw_q.size() - base_aw, 32'd1);
        chk("slverr_b_count", n_b - base_b, 32'd1);
        chk("slverr_bresp", {30'b0, last_bresp}, 32'd2);
        base_s = n_sampled;
        force_bvalid = 1;
        repeat (3) @(posedge clk);
        #1;
        force_bvalid = 0;
        chk("stray_b_count", n_b - base_b, 32'd1);
        chk("stray_no_start", n_sampled - base_s, 32'd0);
        @(negedge clk);
        chk("stray_awvalid", {31'b0, awvalid}, 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
